// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: 4-column x 5-row keypad scanner with frame debounce and a
// key-code queue. Columns are driven active-low one at a time, rows are sampled
// on the last settle cycle of each column, and the four samples of a frame are
// combined into one frame code that must repeat DEB_FRAMES times to be accepted.
// Build option: define KEY_SCAN_FIFO_EN for a 4-entry FIFO queue; otherwise the
// queue is a single holding register.
module key_scan_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DEB_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_row_in,
  input  logic       key_ack,
  output logic [3:0] key_column_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic       key_ovf
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam logic [4:0] CODE_INV = 5'd31;

  logic [SW-1:0]  settle;
  logic [1:0]     col;
  logic           last;
  logic           frame_end;
  logic [2:0][4:0] col_key;
  logic [2:0]     col_inv;
  logic [4:0]     cur_key;
  logic           cur_inv;
  logic [4:0]     fcode;
  logic [4:0]     prev_code;
  logic [3:0]     deb_cnt;
  logic           frame_done;
  logic [4:0]     acc_code;
  logic           stable;
  logic           push;
  logic           pop;
  logic           full;
  logic           do_push;

  assign last      = (settle == SW'(SETTLE_CYC - 1));
  assign frame_end = last && (col == 2'd3);
  assign key_column_out = ~(4'b0001 << col);

  // Decode the current column sample into a key number or an invalid flag.
  always_comb begin
    cur_key = 5'd0;
    cur_inv = 1'b0;
    if (key_row_in == 5'b11111) begin
      cur_key = 5'd0;
    end else if (key_row_in == 5'b01110) begin
      cur_key = 5'(21 + int'(col));
    end else begin
      cur_inv = 1'b1;
      for (int r = 0; r < 5; r++) begin
        if (key_row_in == ~(5'b00001 << r)) begin
          cur_key = 5'(int'(col) * 5 + r + 1);
          cur_inv = 1'b0;
        end
      end
    end
  end

  // Combine the three stored column results and the live column 3 sample.
  always_comb begin
    logic [2:0] nk;
    nk = 3'(col_key[0] != 5'd0) + 3'(col_key[1] != 5'd0)
       + 3'(col_key[2] != 5'd0) + 3'(cur_key != 5'd0);
    if ((|col_inv) || cur_inv)
      fcode = CODE_INV;
    else if (col_key[0] == 5'd1 && col_key[1] == 5'd6 && col_key[2] == 5'd0 && cur_key == 5'd0)
      fcode = 5'd25;
    else if (nk == 3'd0)
      fcode = 5'd0;
    else if (nk == 3'd1)
      fcode = col_key[0] | col_key[1] | col_key[2] | cur_key;
    else
      fcode = CODE_INV;
  end

  // Settle counter, column pointer and per-column sample capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle  <= '0;
      col     <= 2'd0;
      col_key <= '0;
      col_inv <= '0;
    end else if (last) begin
      settle <= '0;
      col    <= col + 2'd1;
      case (col)
        2'd0: begin col_key[0] <= cur_key; col_inv[0] <= cur_inv; end
        2'd1: begin col_key[1] <= cur_key; col_inv[1] <= cur_inv; end
        2'd2: begin col_key[2] <= cur_key; col_inv[2] <= cur_inv; end
        default: ;
      endcase
    end else begin
      settle <= settle + SW'(1);
    end
  end

  // Frame debounce: count repeats of the same frame code, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_code  <= 5'd0;
      deb_cnt    <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        prev_code <= fcode;
        if (fcode == prev_code) begin
          if (deb_cnt != 4'(DEB_FRAMES))
            deb_cnt <= deb_cnt + 4'd1;
        end else begin
          deb_cnt <= 4'd1;
        end
      end
    end
  end

  // Acceptance is evaluated the cycle after frame end on the updated counter.
  assign stable = frame_done && (deb_cnt == 4'(DEB_FRAMES));
  assign push   = stable && (prev_code != 5'd0) && (prev_code <= 5'd25)
                  && (prev_code != acc_code);
  assign pop    = key_ack && key_valid;
  assign do_push = push && (!full || pop);
  assign key_pressed = (acc_code != 5'd0);

  // Accepted (held) key code; invalid frames leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      acc_code <= 5'd0;
    else if (push)
      acc_code <= prev_code;
    else if (stable && prev_code == 5'd0)
      acc_code <= 5'd0;
  end

`ifdef KEY_SCAN_FIFO_EN
  logic [3:0][4:0] mem;
  logic [1:0]      wp;
  logic [1:0]      rp;
  logic [2:0]      cnt;

  assign full      = (cnt == 3'd4);
  assign key_valid = (cnt != 3'd0);
  assign key_code  = key_valid ? mem[rp] : 5'd0;

  // 4-entry circular FIFO; a push into a full queue survives if the head pops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem     <= '0;
      wp      <= 2'd0;
      rp      <= 2'd0;
      cnt     <= 3'd0;
      key_ovf <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wp] <= prev_code;
        wp      <= wp + 2'd1;
      end
      if (pop)
        rp <= rp + 2'd1;
      cnt <= cnt + 3'(do_push) - 3'(pop);
      if (push && full && !pop)
        key_ovf <= 1'b1;
    end
  end
`else
  logic [4:0] hold;
  logic       hold_v;

  assign full      = hold_v;
  assign key_valid = hold_v;
  assign key_code  = hold_v ? hold : 5'd0;

  // Single holding register; a new code replaces a popping head in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold    <= 5'd0;
      hold_v  <= 1'b0;
      key_ovf <= 1'b0;
    end else begin
      if (do_push) begin
        hold   <= prev_code;
        hold_v <= 1'b1;
      end else if (pop) begin
        hold_v <= 1'b0;
      end
      if (push && full && !pop)
        key_ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb_key_scan_ctrl: directed bench for key_scan_ctrl. A small keypad model
// returns the row pattern assigned to whichever column is being driven.
// Frame-aligned stimulus: one frame is 16 cycles with default parameters.
module tb_key_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] key_row_in;
  logic       key_ack;
  logic [3:0] key_column_out;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic       key_ovf;

  logic [4:0] rowpat [4];
  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  int vcyc     = 0;
  logic prev_v = 1'b0;
  int r0;
  int v0;

  key_scan_ctrl #(.SETTLE_CYC(4), .DEB_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .key_row_in(key_row_in), .key_ack(key_ack),
    .key_column_out(key_column_out), .key_code(key_code), .key_valid(key_valid),
    .key_pressed(key_pressed), .key_ovf(key_ovf)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Keypad model: a pressed key pulls its row low only while its column is driven.
  always_comb begin
    case (key_column_out)
      4'b1110: key_row_in = rowpat[0];
      4'b1101: key_row_in = rowpat[1];
      4'b1011: key_row_in = rowpat[2];
      4'b0111: key_row_in = rowpat[3];
      default: key_row_in = 5'b11111;
    endcase
  end

  // Count rising edges and high cycles of key_valid.
  always @(negedge clk) begin
    if (key_valid && !prev_v) rises++;
    if (key_valid) vcyc++;
    prev_v = key_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) rowpat[i] = 5'b11111;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    cyc(16 * n);
  endtask

  task automatic do_reset();
    clr();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    key_ack = 1'b0;
    clr();
    #20;
    chk("rst_col", int'(key_column_out), 4'b1110);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_pressed", int'(key_pressed), 0);
    chk("rst_ovf", int'(key_ovf), 0);

    // Key 8 held 5 frames, then released.
    do_reset();
    r0 = rises;
    rowpat[1] = 5'b11011;
    frames(5);
    chk("k8_rises", rises - r0, 1);
    chk("k8_code", int'(key_code), 8);
    chk("k8_valid", int'(key_valid), 1);
    chk("k8_pressed", int'(key_pressed), 1);
    clr();
    frames(2);
    chk("k8_rel2_pressed", int'(key_pressed), 1);
    frames(1); cyc(2);
    chk("k8_rel3_pressed", int'(key_pressed), 0);
    chk("k8_rel_code", int'(key_code), 8);
    ack_pulse();
    chk("k8_ack_valid", int'(key_valid), 0);
    chk("k8_ack_code", int'(key_code), 0);

    // Key 8 bouncing for 4 frames, then stable.
    do_reset();
    r0 = rises;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) rowpat[1] = 5'b11011; else rowpat[1] = 5'b11111;
      frames(1);
    end
    rowpat[1] = 5'b11011;
    frames(2); cyc(2);
    chk("bnc_early_valid", int'(key_valid), 0);
    frames(1);
    chk("bnc_valid", int'(key_valid), 1);
    chk("bnc_code", int'(key_code), 8);
    chk("bnc_rises", rises - r0, 1);

    // Two-row pattern in column 3, the 1+6 combination, and an invalid pattern.
    do_reset();
    rowpat[3] = 5'b01110;
    frames(3); cyc(2);
    chk("k24_code", int'(key_code), 24);
    do_reset();
    rowpat[0] = 5'b11110;
    rowpat[1] = 5'b11110;
    frames(3); cyc(2);
    chk("k25_code", int'(key_code), 25);
    chk("k25_pressed", int'(key_pressed), 1);
    do_reset();
    rowpat[2] = 5'b11100;
    frames(4);
    chk("inv_valid", int'(key_valid), 0);
    chk("inv_pressed", int'(key_pressed), 0);

    // Keys 3 then 17 without acknowledge.
    do_reset();
    rowpat[0] = 5'b11011;
    frames(3);
    clr();
    frames(3);
    rowpat[3] = 5'b11101;
    frames(3);
    clr();
    frames(3); cyc(2);
    chk("q_code", int'(key_code), 3);
`ifdef KEY_SCAN_FIFO_EN
    chk("q_ovf", int'(key_ovf), 0);
    ack_pulse();
    chk("q_code2", int'(key_code), 17);
    ack_pulse();
    chk("q_empty", int'(key_valid), 0);
`else
    chk("q_ovf", int'(key_ovf), 1);
    ack_pulse();
    chk("q_empty", int'(key_valid), 0);
`endif

    // Reset during column 2 while key 12 is debouncing.
    do_reset();
    rowpat[2] = 5'b11101;
    frames(2); cyc(8);
    rst = 1'b0;
    #1;
    chk("mid_col", int'(key_column_out), 4'b1110);
    chk("mid_valid", int'(key_valid), 0);
    chk("mid_code", int'(key_code), 0);
    chk("mid_pressed", int'(key_pressed), 0);
    chk("mid_ovf", int'(key_ovf), 0);
    @(negedge clk);
    rst = 1'b1;
    frames(2); cyc(2);
    chk("mid_early_valid", int'(key_valid), 0);
    frames(1);
    chk("mid_valid_after", int'(key_valid), 1);
    chk("mid_code_after", int'(key_code), 12);

    // Acknowledge held high across an empty queue, then key 1 accepted.
    do_reset();
    key_ack = 1'b1;
    cyc(4);
    v0 = vcyc;
    rowpat[0] = 5'b11110;
    frames(4);
    chk("ackhi_vcyc", vcyc - v0, 1);
    chk("ackhi_pressed", int'(key_pressed), 1);
    chk("ackhi_ovf", int'(key_ovf), 0);
    key_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4: clk cycles each column is driven; rows are sampled on the last cycle (min 2).
REQ-002 SHALL have parameter DEB_FRAMES, default 3: consecutive identical frame codes required to accept a press or release (1..15).
REQ-003 SHALL have port clk, input, 1: system clock, 10 MHz.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port key_row_in, input, 5: keypad row returns, active-low.
REQ-006 SHALL have port key_ack, input, 1: consumer acknowledge of the head code.
REQ-007 SHALL have port key_column_out, output, 4: column drive, active-low one-hot.
REQ-008 SHALL have port key_code, output, 5: head key code, 1..25.
REQ-009 SHALL have port key_valid, output, 1: key_code holds an unacknowledged code.
REQ-010 SHALL have port key_pressed, output, 1: a debounced key is currently held.
REQ-011 SHALL have port key_ovf, output, 1: sticky flag, set when a code is dropped.

Function
REQ-012 SHALL cycle key_column_out through 1110, 1101, 1011, 0111, with SETTLE_CYC cycles per column, then repeat; four columns form one frame of 4*SETTLE_CYC cycles.
REQ-013 SHALL sample key_row_in on the final settle cycle of each column, then move to the next column on the following cycle.
REQ-014 SHALL decode each sample, for column c (0..3): a single row r low (0..4) gives key c*5+r+1; row pattern 01110 gives key 21+c; 11111 gives no key; any other pattern marks the frame invalid.
REQ-015 SHALL compute the frame code at the end of each frame:
- column 0 key 1 and column 1 key 6 with no other key gives 25;
- exactly one key gives that key;
- no key gives 0;
- otherwise the frame is invalid, code 31.
REQ-016 SHALL keep a debounce counter that increments when the frame code equals the previous frame code, saturates at DEB_FRAMES, and reloads 1 on any change.
REQ-017 SHALL accept a press when the counter reaches DEB_FRAMES with a code in 1..25 that differs from the accepted code: the accepted code is set and the code is enqueued in the cycle after frame end.
REQ-018 SHALL accept a release when the counter reaches DEB_FRAMES with code 0: the accepted code is cleared to 0 and nothing is enqueued.
REQ-019 SHALL ignore code 31 for acceptance and leave the accepted code unchanged.
REQ-020 SHALL drive key_pressed = 1 exactly while the accepted code is non-zero.
REQ-021 SHALL assert key_valid while the queue is non-empty, with key_code = head entry; key_code SHALL be 0 when the queue is empty.
REQ-022 SHALL pop the head when key_ack = 1 and key_valid = 1; key_ack while key_valid = 0 SHALL be ignored.
REQ-023 SHALL, on enqueue and pop in the same cycle with the queue full, perform both so no code is lost.
REQ-024 SHALL, on enqueue into a full queue without a pop, drop the new code and set key_ovf; key_ovf SHALL clear only on reset.
REQ-025 SHALL accept a held key that is released and re-pressed again as a new code.

Reset
REQ-026 SHALL, with rst = 0, immediately drive key_column_out = 1110, key_code = 0, key_valid = 0, key_pressed = 0, key_ovf = 0, and clear the queue, accepted code, debounce counter and settle counter.
REQ-027 SHALL, after rst deasserts mid-frame, restart scanning at column 0 with the first settle cycle on the first clk edge; a partial frame SHALL never be evaluated.

Configuration
REQ-028 SHALL, with KEY_SCAN_FIFO_EN defined, use a 4-entry FIFO as the queue.
REQ-029 SHALL, without KEY_SCAN_FIFO_EN, use a 1-entry holding register as the queue, with full = key_valid.

Verification
REQ-030 SHALL cover: key 8 (column 1, row 2 low) held for 5 frames -> key_valid rises once with key_code = 8 and key_pressed = 1; release for 3 frames -> key_pressed = 0.
REQ-031 SHALL cover: key 8 bouncing (present/absent alternating frames for 4 frames), then stable -> exactly one enqueue of 8, only after 3 stable frames.
REQ-032 SHALL cover: row 01110 in column 3 -> code 24; row 0 in columns 0 and 1 -> code 25; rows 11100 in column 2 -> no enqueue.
REQ-033 SHALL cover, without the macro: keys 3 then 17 pressed and released with no ack -> key_code = 3, key_ovf = 1; with the macro: both queued, acks return 3 then 17 and key_ovf = 0.
REQ-034 SHALL cover: rst pulsed low during column 2 while key 12 is debouncing -> all outputs at reset values, no enqueue of 12 until 3 full new frames.
REQ-035 SHALL cover: key_ack held high with an empty queue, then key 1 accepted -> key_valid high for exactly one cycle.
